// File: rtl/bram_burst_reader.sv
// Burst read sequencer for a 1-cycle-latency block RAM port.
// Converts (addr, len) commands into a valid/ready word stream through a small output FIFO.
module bram_burst_reader #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic              done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int LW = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FIN} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr_ptr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LW-1:0]     r_rem_issue;
  logic [LW-1:0]     r_rem_out;
  logic              r_inflight;
  logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic          w_accept;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_occ;
  logic          w_last_issue;
  logic          w_last_pop;

  assign cmd_ready = (r_state == S_IDLE) && !rst;
  assign w_accept  = cmd_valid && cmd_ready;

  // Reserve a FIFO slot for the word still coming out of the RAM so backpressure never overflows.
  assign w_occ   = r_count + CW'(r_inflight);
  assign w_issue = (r_state == S_READ) && (r_rem_issue != '0) && (w_occ < CW'(FIFO_DEPTH));
  assign w_push  = r_inflight;
  assign w_pop   = m_valid && m_ready;

  assign w_last_issue = w_issue && (r_rem_issue == LW'(1));
  assign w_last_pop   = w_pop && (r_rem_out == LW'(1));

  assign mem_addr = w_issue ? r_addr_ptr : r_mem_addr;
  assign mem_we   = 1'b0;
  assign mem_din  = '0;

  assign m_valid = (r_count != '0);
  assign m_data  = m_valid ? r_fifo[r_rd_ptr] : '0;

  assign busy = (r_state != S_IDLE) || w_accept;
  assign done = (r_state == S_FIN);

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= mem_dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr_ptr  <= '0;
      r_mem_addr  <= '0;
      r_rem_issue <= '0;
      r_rem_out   <= '0;
      r_inflight  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_mem_addr  <= r_addr_ptr;
        r_addr_ptr  <= r_addr_ptr + ADDR_W'(1);
        r_rem_issue <= r_rem_issue - LW'(1);
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PW'(1);
        r_rem_out <= r_rem_out - LW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr_ptr  <= cmd_addr;
            r_rem_issue <= cmd_len;
            r_rem_out   <= cmd_len;
            r_state     <= (cmd_len == '0) ? S_FIN : S_READ;
          end
        end
        S_READ: begin
          if (w_last_issue) r_state <= w_last_pop ? S_FIN : S_DRAIN;
        end
        S_DRAIN: begin
          if (w_last_pop) r_state <= S_FIN;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_burst_reader.sv
// Self-checking bench: behavioural 16K-word RAM with registered read, bursts checked
// against words computed straight from RAM contents and address arithmetic.
module tb_bram_burst_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [13:0] cmd_addr = '0;
  logic [14:0] cmd_len = '0;
  logic [13:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_din;
  logic [31:0] mem_dout = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int ovf_cnt = 0;

  logic [31:0] ram [0:16383];
  logic [31:0] got_q [$];

  bram_burst_reader dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_din(mem_din), .mem_dout(mem_dout), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_dout <= ram[mem_addr];

  always @(negedge clk)
    if (!rst && (int'(dut.r_count) + int'(dut.r_inflight)) > 4) ovf_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] exp_word(input logic [13:0] a, input int i);
    logic [13:0] x;
    x = a + 14'(i);
    return ram[x];
  endfunction

  function automatic logic pick_ready(input int mode);
    return (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
  endfunction

  // Drives one command and collects beats until done; cycle 0 is the first cycle cmd_valid is up.
  task automatic run_burst(input logic [13:0] a, input logic [14:0] l, input int mode,
                           output int t_acc, output int t_first, output int t_done,
                           output int busy_cnt, output int nvalid);
    got_q.delete();
    t_acc = -1; t_first = -1; t_done = -1; busy_cnt = 0; nvalid = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; m_ready = pick_ready(mode);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (cmd_valid && cmd_ready && t_acc < 0) t_acc = c;
      if (m_valid) begin
        nvalid++;
        if (t_first < 0) t_first = c;
      end
      if (m_valid && m_ready) got_q.push_back(m_data);
      if (done) begin
        t_done = c;
        break;
      end
      @(posedge clk); #1;
      if (t_acc >= 0) cmd_valid = 1'b0;
      m_ready = pick_ready(mode);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %0b exp 0", cmd_ready); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_rst_cmd_ready got %0b exp 1", cmd_ready); end
    checks++;
    if ({m_valid, busy, done, mem_we} !== 4'b0) begin
      errors++; $display("FAIL post_rst_flags got %b exp 0000", {m_valid, busy, done, mem_we});
    end
    checks++;
    if (m_data !== 32'd0 || mem_din !== 32'd0) begin
      errors++; $display("FAIL post_rst_data got %0h/%0h exp 0/0", m_data, mem_din);
    end
    checks++;
    if (mem_addr !== 14'd0) begin errors++; $display("FAIL post_rst_mem_addr got %0d exp 0", mem_addr); end
  endtask

  task automatic test_basic;
    int ta, tf, td, bc, nv;
    run_burst(14'd100, 15'd8, 0, ta, tf, td, bc, nv);
    checks++;
    if (td < 0 || got_q.size() != 8) begin
      errors++; $display("FAIL basic_count got %0d beats done_cyc %0d exp 8", got_q.size(), td);
    end
    for (int i = 0; i < got_q.size() && i < 8; i++) begin
      checks++;
      if (got_q[i] !== 32'(100 + i)) begin
        errors++; $display("FAIL basic_data[%0d] got %0d exp %0d", i, got_q[i], 100 + i);
      end
    end
    checks++;
    if (tf - ta != 3) begin errors++; $display("FAIL basic_first_valid got %0d exp 3", tf - ta); end
    // Full throughput: 8 beats on consecutive cycles, then done right after the last one.
    checks++;
    if (td - tf != 8) begin errors++; $display("FAIL basic_done_cycle got %0d exp 8", td - tf); end
    checks++;
    if (bc != td - ta + 1) begin errors++; $display("FAIL basic_busy got %0d exp %0d", bc, td - ta + 1); end
  endtask

  task automatic test_wrap;
    int ta, tf, td, bc, nv;
    logic [31:0] expv [4];
    expv[0] = ram[16382]; expv[1] = ram[16383]; expv[2] = ram[0]; expv[3] = ram[1];
    run_burst(14'd16382, 15'd4, 0, ta, tf, td, bc, nv);
    checks++;
    if (got_q.size() != 4) begin errors++; $display("FAIL wrap_count got %0d exp 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      checks++;
      if (got_q[i] !== expv[i]) begin
        errors++; $display("FAIL wrap_data[%0d] got %0h exp %0h", i, got_q[i], expv[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    int ta, tf, td, bc, nv, ovf0;
    logic [13:0] a;
    logic [14:0] l;
    ovf0 = ovf_cnt;
    for (int k = 0; k < 8; k++) begin
      a = (k % 3 == 2) ? 14'(16384 - $urandom_range(1, 10)) : 14'($urandom);
      l = (k == 0) ? 15'd8 : 15'($urandom_range(1, 40));
      run_burst(a, l, 1, ta, tf, td, bc, nv);
      checks++;
      if (td < 0 || got_q.size() != int'(l)) begin
        errors++; $display("FAIL bp_count[%0d] got %0d exp %0d", k, got_q.size(), l);
      end
      for (int i = 0; i < got_q.size() && i < int'(l); i++) begin
        checks++;
        if (got_q[i] !== exp_word(a, i)) begin
          errors++; $display("FAIL bp_data[%0d][%0d] got %0h exp %0h", k, i, got_q[i], exp_word(a, i));
        end
      end
    end
    checks++;
    if (ovf_cnt != ovf0) begin errors++; $display("FAIL bp_occupancy got %0d overflows exp 0", ovf_cnt - ovf0); end
  endtask

  task automatic test_len0;
    int ta, tf, td, bc, nv;
    run_burst(14'd77, 15'd0, 0, ta, tf, td, bc, nv);
    checks++;
    if (nv != 0) begin errors++; $display("FAIL len0_valid got %0d cycles exp 0", nv); end
    checks++;
    if (bc != 2) begin errors++; $display("FAIL len0_busy got %0d exp 2", bc); end
    // Accept cycle, then FIN carries done.
    checks++;
    if (td - ta != 1) begin errors++; $display("FAIL len0_done got %0d exp 1", td - ta); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL len0_after got busy %0b done %0b exp 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back;
    int acc [2];
    int dn [2];
    int na = 0, nd = 0;
    logic [13:0] aa = 14'd200, ab = 14'd300;
    got_q.delete();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = aa; cmd_len = 15'd5; m_ready = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (cmd_valid && cmd_ready && na < 2) begin acc[na] = c; na++; end
      if (m_valid && m_ready) got_q.push_back(m_data);
      if (done) begin
        dn[nd] = c; nd++;
        if (nd == 2) break;
      end
      @(posedge clk); #1;
      if (na == 1) begin cmd_addr = ab; cmd_len = 15'd3; end
      if (na == 2) cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    checks++;
    if (na != 2 || nd != 2) begin
      errors++; $display("FAIL b2b_progress got %0d accepts %0d dones exp 2 2", na, nd);
    end else begin
      checks++;
      if (acc[1] != dn[0] + 1) begin
        errors++; $display("FAIL b2b_second_accept got %0d exp %0d", acc[1], dn[0] + 1);
      end
    end
    checks++;
    if (got_q.size() != 8) begin errors++; $display("FAIL b2b_count got %0d exp 8", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 8; i++) begin
      checks++;
      if (got_q[i] !== ((i < 5) ? exp_word(aa, i) : exp_word(ab, i - 5))) begin
        errors++; $display("FAIL b2b_data[%0d] got %0h", i, got_q[i]);
      end
    end
  endtask

  task automatic test_midburst_reset;
    int ta, tf, td, bc, nv, beats = 0;
    bit saw_done = 1'b0;
    bit pre_ok = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_addr = 14'd500; cmd_len = 15'd16; m_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        if (m_data !== exp_word(14'd500, beats)) pre_ok = 1'b0;
        beats++;
      end
      if (beats == 4) break;
      @(posedge clk); #1 cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    checks++;
    if (beats != 4 || !pre_ok) begin errors++; $display("FAIL mid_pre_rst got %0d beats ok %0b exp 4 1", beats, pre_ok); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_valid, busy, done} !== 3'b000) begin
      errors++; $display("FAIL mid_rst_flags got %b exp 000", {m_valid, busy, done});
    end
    repeat (30) begin
      @(negedge clk);
      if (done || m_valid) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL mid_rst_quiet got activity exp none"); end
    run_burst(14'd600, 15'd2, 0, ta, tf, td, bc, nv);
    checks++;
    if (got_q.size() != 2) begin errors++; $display("FAIL mid_after_count got %0d exp 2", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      checks++;
      if (got_q[i] !== exp_word(14'd600, i)) begin
        errors++; $display("FAIL mid_after_data[%0d] got %0h exp %0h", i, got_q[i], exp_word(14'd600, i));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = $urandom;
    for (int i = 100; i < 108; i++) ram[i] = 32'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len0();
    test_back_to_back();
    test_midburst_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
